// File: rtl/fpu_issue_queue.sv
// FPU request front end: tagged request FIFO, one-at-a-time issue to the FPU,
// and a held valid/ready response port carrying result and originating tag.
module fpu_issue_queue #(
  parameter int C_OP  = 32,
  parameter int C_RM  = 3,
  parameter int C_CMD = 4,
  parameter int DEPTH = 4,
  parameter int C_TAG = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [C_OP-1:0]  req_operand_a_i,
  input  logic [C_OP-1:0]  req_operand_b_i,
  input  logic [C_RM-1:0]  req_rm_i,
  input  logic [C_CMD-1:0] req_op_i,
  input  logic [C_TAG-1:0] req_tag_i,
  input  logic             flush_i,
  output logic [C_OP-1:0]  fpu_operand_a_o,
  output logic [C_OP-1:0]  fpu_operand_b_o,
  output logic [C_RM-1:0]  fpu_rm_o,
  output logic [C_CMD-1:0] fpu_op_o,
  output logic             fpu_enable_o,
  input  logic [C_OP-1:0]  fpu_result_i,
  input  logic             fpu_valid_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [C_OP-1:0]  resp_result_o,
  output logic [C_TAG-1:0] resp_tag_o,
  output logic             busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = C_TAG + 2 * C_OP + C_RM + C_CMD;
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e state_q, state_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push, pop, res_ld, empty;

  logic [C_TAG-1:0] head_tag;
  logic [C_OP-1:0]  head_a, head_b;
  logic [C_RM-1:0]  head_rm;
  logic [C_CMD-1:0] head_op;

  logic [C_OP-1:0]  ia_q, ib_q, rres_q;
  logic [C_RM-1:0]  irm_q;
  logic [C_CMD-1:0] iop_q;
  logic [C_TAG-1:0] itag_q, rtag_q;

  assign empty       = (cnt_q == '0);
  assign req_ready_o = (cnt_q != CNT_FULL) && !flush_i;
  assign push        = req_valid_i && req_ready_o;
  assign {head_tag, head_a, head_b, head_rm, head_op} = mem_q[rptr_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    res_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !flush_i) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (fpu_valid_i) begin
          res_ld  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          if (!empty && !flush_i) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // flush_i already blocks push (via req_ready_o) and pop, so clearing wins outright.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_tag_i, req_operand_a_i, req_operand_b_i, req_rm_i, req_op_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ia_q    <= '0;
      ib_q    <= '0;
      irm_q   <= '0;
      iop_q   <= '0;
      itag_q  <= '0;
      rres_q  <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        ia_q   <= head_a;
        ib_q   <= head_b;
        irm_q  <= head_rm;
        iop_q  <= head_op;
        itag_q <= head_tag;
      end
      if (res_ld) begin
        rres_q <= fpu_result_i;
        rtag_q <= itag_q;
      end
    end
  end

  assign fpu_operand_a_o = ia_q;
  assign fpu_operand_b_o = ib_q;
  assign fpu_rm_o        = irm_q;
  assign fpu_op_o        = iop_q;
  assign fpu_enable_o    = (state_q == EXEC);
  assign resp_valid_o    = (state_q == RESP);
  assign resp_result_o   = rres_q;
  assign resp_tag_o      = rtag_q;
  assign busy_o          = !empty || (state_q != IDLE);

endmodule
